// File: rtl/ccip_avmm_burst_splitter.sv
// CCI-P style burst command to per-line AVMM request splitter.
// Optional stats counters: define CCIP_AVMM_BURST_SPLITTER_STATS_EN.
module ccip_avmm_burst_splitter #(
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 512,
  parameter int BURST_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_write,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [BURST_WIDTH-1:0] in_burst,
  input  logic [DATA_WIDTH-1:0]  in_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_write,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [DATA_WIDTH-1:0]  out_wdata,
  output logic                   out_sop,
  output logic                   out_eop,
  output logic                   err_burst,
  output logic                   busy
`ifdef CCIP_AVMM_BURST_SPLITTER_STATS_EN
  ,
  output logic [31:0]            stat_cmds,
  output logic [31:0]            stat_beats
`endif
);

  localparam int unsigned MAX_BURST = 1 << (BURST_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_SPLIT,
    WR_BEATS
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [BURST_WIDTH-1:0] r_remaining;
  logic [BURST_WIDTH-1:0] w_rem_nxt;
  logic [ADDR_WIDTH-1:0]  r_next_addr;
  logic [ADDR_WIDTH-1:0]  w_addr_nxt;

  logic                   r_out_valid;
  logic                   r_out_write;
  logic [ADDR_WIDTH-1:0]  r_out_addr;
  logic [DATA_WIDTH-1:0]  r_out_wdata;
  logic                   r_out_sop;
  logic                   r_out_eop;

  logic                   w_free;
  logic                   w_illegal;
  logic                   w_multi;
  logic                   w_in_ready;
  logic                   w_load;
  logic                   w_first;
  logic                   w_err;
  logic                   w_beat_write;
  logic [ADDR_WIDTH-1:0]  w_beat_addr;
  logic [DATA_WIDTH-1:0]  w_beat_wdata;
  logic                   w_beat_sop;
  logic                   w_beat_eop;

  // Output register can take a beat when empty or draining this cycle.
  assign w_free    = !r_out_valid || out_ready;
  assign w_illegal = (in_burst == '0) ||
                     (32'(in_burst) > MAX_BURST);
  assign w_multi   = !w_illegal &&
                     (in_burst != BURST_WIDTH'(1));

  // Next-state, beat selection and input handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_remaining;
    w_addr_nxt   = r_next_addr;
    w_in_ready   = 1'b0;
    w_load       = 1'b0;
    w_first      = 1'b0;
    w_err        = 1'b0;
    w_beat_write = r_out_write;
    w_beat_addr  = r_next_addr;
    w_beat_wdata = in_wdata;
    w_beat_sop   = 1'b0;
    w_beat_eop   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = w_free;
        if (in_valid && w_free) begin
          w_first      = 1'b1;
          w_load       = 1'b1;
          w_err        = w_illegal;
          w_beat_write = in_write;
          w_beat_addr  = in_addr;
          w_beat_sop   = 1'b1;
          w_beat_eop   = !w_multi;
          w_addr_nxt   = in_addr + ADDR_WIDTH'(1);
          w_rem_nxt    = '0;
          if (w_multi) begin
            w_rem_nxt   = in_burst - BURST_WIDTH'(1);
            w_state_nxt = in_write ? WR_BEATS : RD_SPLIT;
          end
        end
      end
      RD_SPLIT: begin
        if (w_free) begin
          w_load       = 1'b1;
          w_beat_write = 1'b0;
          w_beat_eop   = (r_remaining == BURST_WIDTH'(1));
          w_rem_nxt    = r_remaining - BURST_WIDTH'(1);
          w_addr_nxt   = r_next_addr + ADDR_WIDTH'(1);
          if (w_beat_eop)
            w_state_nxt = IDLE;
        end
      end
      WR_BEATS: begin
        w_in_ready = w_free;
        if (in_valid && w_free) begin
          w_load       = 1'b1;
          w_beat_write = 1'b1;
          w_beat_eop   = (r_remaining == BURST_WIDTH'(1));
          w_rem_nxt    = r_remaining - BURST_WIDTH'(1);
          w_addr_nxt   = r_next_addr + ADDR_WIDTH'(1);
          if (w_beat_eop)
            w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (reset) begin
      w_in_ready = 1'b0;
      w_first    = 1'b0;
      w_err      = 1'b0;
    end
  end

  // State, burst tracking and the single output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_next_addr <= '0;
      r_out_valid <= 1'b0;
      r_out_write <= 1'b0;
      r_out_addr  <= '0;
      r_out_wdata <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_next_addr <= w_addr_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_write <= w_beat_write;
        r_out_addr  <= w_beat_addr;
        r_out_wdata <= w_beat_wdata;
        r_out_sop   <= w_beat_sop;
        r_out_eop   <= w_beat_eop;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_write = r_out_write;
  assign out_addr  = r_out_addr;
  assign out_wdata = r_out_wdata;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign err_burst = w_err;
  assign busy      = (r_state != IDLE) || r_out_valid;

`ifdef CCIP_AVMM_BURST_SPLITTER_STATS_EN
  logic [31:0] r_stat_cmds;
  logic [31:0] r_stat_beats;

  // Saturating counts of accepted commands and delivered beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_cmds  <= '0;
      r_stat_beats <= '0;
    end else begin
      if (w_first && (r_stat_cmds != '1))
        r_stat_cmds <= r_stat_cmds + 32'd1;
      if (r_out_valid && out_ready && (r_stat_beats != '1))
        r_stat_beats <= r_stat_beats + 32'd1;
    end
  end

  assign stat_cmds  = r_stat_cmds;
  assign stat_beats = r_stat_beats;
`endif

endmodule
